gme_lookup_arb: RTL and testbench

GME_LOOKUP_ARB -- requirements
Module: gme_lookup_arb

---
 rtl/gme_arb_pkg.sv | 22 ++
 rtl/gme_arb_tag_fifo.sv | 66 ++++++
 rtl/gme_lookup_arb.sv | 204 ++++++++++++++++++++
 tb/tb_gme_lookup_arb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gme_arb_pkg.sv
// Shared constants, the tag type and a small popcount helper for the lookup arbiter.
package gme_arb_pkg;

  localparam int KEY_W   = 512;
  localparam int INDEX_W = 16;
  localparam int MAX_REQ = 4;
  localparam int TAG_W   = 2;

  // Tag identifies the requester that issued a lookup; wide enough for MAX_REQ.
  typedef logic [TAG_W-1:0] tag_t;

  // Number of set bits in a requester-wide vector (used to count same-cycle drops).
  function automatic logic [2:0] count_ones(input logic [MAX_REQ-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gme_arb_tag_fifo.sv
// Synchronous FIFO of requester tags for lookups still awaiting an index.
// Push is ignored when full and pop when empty, so a push into an empty
// FIFO cannot be popped in the same cycle.
module gme_arb_tag_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 1
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dout,
  output logic [$clog2(DEPTH):0]     o_usedw,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_U    = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P    = AW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_usedw;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_usedw == '0);
  assign o_full  = (r_usedw == FULL_LVL);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_usedw = r_usedw;

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps usedw.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ONE_P;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ONE_P;
      end
      case ({w_push, w_pop})
        2'b10:   r_usedw <= r_usedw + ONE_U;
        2'b01:   r_usedw <= r_usedw - ONE_U;
        default: r_usedw <= r_usedw;
      endcase
    end
  end

endmodule

// File: rtl/gme_lookup_arb.sv
// Round-robin arbiter sharing one lookup engine between NUM_REQ key requesters.
// Each requester has a one-entry key holding register; issued lookups are
// tagged in order so returned indexes are steered back to their owner.
module gme_lookup_arb
  import gme_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic [NUM_REQ-1:0]           in_req_key_wr,
  input  logic [NUM_REQ*KEY_W-1:0]     in_req_key,
  output logic [NUM_REQ-1:0]           out_req_key_alf,
  output logic                         out_lkp_key_wr,
  output logic [KEY_W-1:0]             out_lkp_key,
  input  logic                         in_lkp_key_alf,
  input  logic                         in_lkp_index_wr,
  input  logic [INDEX_W-1:0]           in_lkp_index,
  output logic [NUM_REQ-1:0]           out_req_index_wr,
  output logic [INDEX_W-1:0]           out_req_index,
  input  logic                         cfg_arb_en,
  output logic [NUM_REQ*32-1:0]        out_grant_count,
  output logic [31:0]                  out_drop_count,
  output logic [31:0]                  out_orphan_count,
  output logic [$clog2(TAG_DEPTH):0]   out_tag_usedw
);

  localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int UW = $clog2(TAG_DEPTH) + 1;
  localparam logic [UW-1:0] ALF_LVL = UW'(TAG_DEPTH - 2);

  logic [NUM_REQ-1:0] r_hold_vld;
  logic [KEY_W-1:0]   r_hold_key [NUM_REQ];
  logic [TW-1:0]      r_rr_ptr;
  logic               r_lkp_key_wr;
  logic [KEY_W-1:0]   r_lkp_key;
  logic [NUM_REQ-1:0] r_idx_wr;
  logic [INDEX_W-1:0] r_idx;
  logic [31:0]        r_grant_cnt [NUM_REQ];
  logic [31:0]        r_drop_cnt;
  logic [31:0]        r_orphan_cnt;

  logic               w_gnt_allow;
  logic               w_gnt_vld;
  logic [TW-1:0]      w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [NUM_REQ-1:0] w_load;
  logic [NUM_REQ-1:0] w_drop;
  logic [2:0]         w_drop_num;
  logic [NUM_REQ-1:0] w_head_oh;
  tag_t               w_head_tag;
  logic [TW-1:0]      w_fifo_dout;
  logic [UW-1:0]      w_usedw;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_pop;
  logic               w_orphan;

  // Requester index k positions after ptr, modulo NUM_REQ.
  function automatic logic [TW-1:0] rr_idx(input logic [TW-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end
    return s[TW-1:0];
  endfunction

  assign w_gnt_allow = cfg_arb_en & ~in_lkp_key_alf & ~w_fifo_full & (|r_hold_vld);
  assign w_pop       = in_lkp_index_wr & ~w_fifo_empty;
  assign w_orphan    = in_lkp_index_wr & w_fifo_empty;
  assign w_head_tag  = tag_t'(w_fifo_dout);

  // Round-robin search: scanning backwards lets the requester nearest rr_ptr win.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (w_gnt_allow) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (r_hold_vld[rr_idx(r_rr_ptr, k)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = rr_idx(r_rr_ptr, k);
        end else begin
          w_gnt_vld = w_gnt_vld;
        end
      end
    end else begin
      w_gnt_vld = 1'b0;
    end
  end

  // Per-requester decode of grant, load, drop and delivery target.
  always_comb begin
    w_gnt_oh  = '0;
    w_load    = '0;
    w_drop    = '0;
    w_head_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_oh[i]  = w_gnt_vld & (w_gnt_idx == TW'(i));
      w_load[i]    = in_req_key_wr[i] & (~r_hold_vld[i] | w_gnt_oh[i]);
      w_drop[i]    = in_req_key_wr[i] & r_hold_vld[i] & ~w_gnt_oh[i];
      w_head_oh[i] = (w_head_tag == tag_t'(i));
    end
    w_drop_num = count_ones(MAX_REQ'(w_drop));
  end

  // Key holding registers: reload wins over the clear caused by a grant.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_hold_vld <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_hold_key[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_load[i]) begin
          r_hold_vld[i] <= 1'b1;
          r_hold_key[i] <= in_req_key[i*KEY_W +: KEY_W];
        end else if (w_gnt_oh[i]) begin
          r_hold_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Registered key issue to the lookup engine and round-robin pointer advance.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_lkp_key_wr <= 1'b0;
      r_lkp_key    <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_lkp_key_wr <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_lkp_key <= r_hold_key[w_gnt_idx];
        r_rr_ptr  <= rr_idx(w_gnt_idx, 1);
      end
    end
  end

  // Index delivery to the requester whose tag heads the FIFO.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_idx_wr <= '0;
      r_idx    <= '0;
    end else begin
      r_idx_wr <= w_pop ? w_head_oh : '0;
      if (w_pop) begin
        r_idx <= in_lkp_index;
      end
    end
  end

  // Statistics counters, all free-running and wrapping at 32 bits.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_drop_cnt   <= '0;
      r_orphan_cnt <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_grant_cnt[i] <= '0;
      end
    end else begin
      r_drop_cnt <= r_drop_cnt + {29'd0, w_drop_num};
      if (w_orphan) begin
        r_orphan_cnt <= r_orphan_cnt + 32'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt_oh[i]) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
        end
      end
    end
  end

  gme_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TW)
  ) u_tag_fifo (
    .clk     (clk),
    .srst    (srst),
    .i_push  (w_gnt_vld),
    .i_din   (w_gnt_idx),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_usedw (w_usedw),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign out_grant_count[g*32 +: 32] = r_grant_cnt[g];
  end

  assign out_req_key_alf  = r_hold_vld | {NUM_REQ{(w_usedw >= ALF_LVL)}};
  assign out_lkp_key_wr   = r_lkp_key_wr;
  assign out_lkp_key      = r_lkp_key;
  assign out_req_index_wr = r_idx_wr;
  assign out_req_index    = r_idx;
  assign out_drop_count   = r_drop_cnt;
  assign out_orphan_count = r_orphan_cnt;
  assign out_tag_usedw    = w_usedw;

endmodule

// File: tb/tb_gme_lookup_arb.sv
// Directed scenario bench for gme_lookup_arb with a key/index scoreboard.
module tb_gme_lookup_arb;
  import gme_arb_pkg::*;

  localparam int NR = 2;
  localparam int TD = 32;

  logic                  clk;
  logic                  srst;
  logic [NR-1:0]         in_req_key_wr;
  logic [NR*KEY_W-1:0]   in_req_key;
  logic [NR-1:0]         out_req_key_alf;
  logic                  out_lkp_key_wr;
  logic [KEY_W-1:0]      out_lkp_key;
  logic                  in_lkp_key_alf;
  logic                  in_lkp_index_wr;
  logic [INDEX_W-1:0]    in_lkp_index;
  logic [NR-1:0]         out_req_index_wr;
  logic [INDEX_W-1:0]    out_req_index;
  logic                  cfg_arb_en;
  logic [NR*32-1:0]      out_grant_count;
  logic [31:0]           out_drop_count;
  logic [31:0]           out_orphan_count;
  logic [$clog2(TD):0]   out_tag_usedw;

  int checks = 0;
  int errors = 0;

  logic [KEY_W-1:0]       exp_key_q [$];
  logic [NR+INDEX_W-1:0]  exp_idx_q [$];

  gme_lookup_arb #(.NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
    .clk              (clk),
    .srst             (srst),
    .in_req_key_wr    (in_req_key_wr),
    .in_req_key       (in_req_key),
    .out_req_key_alf  (out_req_key_alf),
    .out_lkp_key_wr   (out_lkp_key_wr),
    .out_lkp_key      (out_lkp_key),
    .in_lkp_key_alf   (in_lkp_key_alf),
    .in_lkp_index_wr  (in_lkp_index_wr),
    .in_lkp_index     (in_lkp_index),
    .out_req_index_wr (out_req_index_wr),
    .out_req_index    (out_req_index),
    .cfg_arb_en       (cfg_arb_en),
    .out_grant_count  (out_grant_count),
    .out_drop_count   (out_drop_count),
    .out_orphan_count (out_orphan_count),
    .out_tag_usedw    (out_tag_usedw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every issued key and delivered index must match the queues.
  initial begin
    logic [KEY_W-1:0]      ek;
    logic [NR+INDEX_W-1:0] ei;
    forever begin
      @(negedge clk);
      if (out_lkp_key_wr !== 1'b0) begin
        checks++;
        if (exp_key_q.size() == 0) begin
          errors++;
          $display("FAIL lkp_key_unexpected: got wr=%b key=%h required no issue", out_lkp_key_wr, out_lkp_key[63:0]);
        end else begin
          ek = exp_key_q.pop_front();
          if (out_lkp_key !== ek) begin
            errors++;
            $display("FAIL lkp_key: got %h required %h", out_lkp_key[63:0], ek[63:0]);
          end
        end
      end
      if (out_req_index_wr !== '0) begin
        checks++;
        if (exp_idx_q.size() == 0) begin
          errors++;
          $display("FAIL index_unexpected: got wr=%b idx=%h required no delivery", out_req_index_wr, out_req_index);
        end else begin
          ei = exp_idx_q.pop_front();
          if ({out_req_index_wr, out_req_index} !== ei) begin
            errors++;
            $display("FAIL index_delivery: got wr=%b idx=%h required wr=%b idx=%h",
                     out_req_index_wr, out_req_index, ei[NR+INDEX_W-1:INDEX_W], ei[INDEX_W-1:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (exp_key_q.size() == 0 && exp_idx_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    tick();
    tick();
    checks++; if (out_lkp_key_wr !== 1'b0) begin errors++; $display("FAIL rst_lkp_wr: got %b required 0", out_lkp_key_wr); end
    checks++; if (out_lkp_key !== '0) begin errors++; $display("FAIL rst_lkp_key: got %h required 0", out_lkp_key[63:0]); end
    checks++; if (out_req_index_wr !== 2'b00) begin errors++; $display("FAIL rst_idx_wr: got %b required 00", out_req_index_wr); end
    checks++; if (out_req_index !== 16'h0000) begin errors++; $display("FAIL rst_idx: got %h required 0000", out_req_index); end
    checks++; if (out_tag_usedw !== 6'd0) begin errors++; $display("FAIL rst_usedw: got %0d required 0", out_tag_usedw); end
    checks++; if (out_grant_count !== 64'd0) begin errors++; $display("FAIL rst_grant: got %h required 0", out_grant_count); end
    checks++; if (out_drop_count !== 32'd0 || out_orphan_count !== 32'd0) begin errors++; $display("FAIL rst_drop_orphan: got %0d/%0d required 0/0", out_drop_count, out_orphan_count); end
    checks++; if (out_req_key_alf !== 2'b00) begin errors++; $display("FAIL rst_alf: got %b required 00", out_req_key_alf); end
    srst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    in_req_key_wr = 2'b01;
    in_req_key[0 +: KEY_W] = 512'hA5;
    exp_key_q.push_back(512'hA5);
    tick();
    in_req_key_wr = 2'b00;
    checks++; if (out_req_key_alf !== 2'b01) begin errors++; $display("FAIL single_alf: got %b required 01", out_req_key_alf); end
    checks++; if (out_lkp_key_wr !== 1'b0) begin errors++; $display("FAIL single_early: got %b required 0", out_lkp_key_wr); end
    tick();
    checks++; if (out_lkp_key_wr !== 1'b1 || out_lkp_key !== 512'hA5) begin errors++; $display("FAIL single_issue: got wr=%b key=%h required wr=1 key=a5", out_lkp_key_wr, out_lkp_key[63:0]); end
    checks++; if (out_tag_usedw !== 6'd1) begin errors++; $display("FAIL single_usedw: got %0d required 1", out_tag_usedw); end
    tick();
    checks++; if (out_lkp_key_wr !== 1'b0 || out_lkp_key !== 512'hA5) begin errors++; $display("FAIL single_hold: got wr=%b key=%h required wr=0 key=a5", out_lkp_key_wr, out_lkp_key[63:0]); end
    in_lkp_index_wr = 1'b1;
    in_lkp_index = 16'h0123;
    exp_idx_q.push_back({2'b01, 16'h0123});
    tick();
    in_lkp_index_wr = 1'b0;
    checks++; if (out_req_index_wr !== 2'b01 || out_req_index !== 16'h0123) begin errors++; $display("FAIL single_deliver: got wr=%b idx=%h required 01/0123", out_req_index_wr, out_req_index); end
    checks++; if (out_tag_usedw !== 6'd0) begin errors++; $display("FAIL single_usedw_after: got %0d required 0", out_tag_usedw); end
    tick();
    checks++; if (out_req_index_wr !== 2'b00) begin errors++; $display("FAIL single_deliver_pulse: got %b required 00", out_req_index_wr); end
    wait_drain(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain: got %0d/%0d pending required 0/0", exp_key_q.size(), exp_idx_q.size()); end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      in_req_key_wr = 2'b11;
      in_req_key[0 +: KEY_W]     = KEY_W'(32'h100 + p);
      in_req_key[KEY_W +: KEY_W] = KEY_W'(32'h200 + p);
      exp_key_q.push_back(KEY_W'(32'h100 + p));
      exp_key_q.push_back(KEY_W'(32'h200 + p));
      tick();
      in_req_key_wr = 2'b00;
      tick();
    end
    repeat (3) tick();
    checks++; if (out_grant_count[31:0] !== 32'd4 || out_grant_count[63:32] !== 32'd4) begin errors++; $display("FAIL cont_grants: got %0d/%0d required 4/4", out_grant_count[31:0], out_grant_count[63:32]); end
    checks++; if (out_drop_count !== 32'd0) begin errors++; $display("FAIL cont_drop: got %0d required 0", out_drop_count); end
    checks++; if (out_tag_usedw !== 6'd8) begin errors++; $display("FAIL cont_usedw: got %0d required 8", out_tag_usedw); end
    for (int j = 0; j < 8; j++) begin
      in_lkp_index_wr = 1'b1;
      in_lkp_index = INDEX_W'(16'h0200 + j);
      exp_idx_q.push_back({((j % 2) == 0) ? 2'b01 : 2'b10, INDEX_W'(16'h0200 + j)});
      tick();
    end
    in_lkp_index_wr = 1'b0;
    wait_drain(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont_drain: got %0d/%0d pending required 0/0", exp_key_q.size(), exp_idx_q.size()); end
    checks++; if (out_tag_usedw !== 6'd0) begin errors++; $display("FAIL cont_usedw_end: got %0d required 0", out_tag_usedw); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    in_lkp_key_alf = 1'b1;
    in_req_key_wr = 2'b11;
    in_req_key[0 +: KEY_W]     = 512'hC0;
    in_req_key[KEY_W +: KEY_W] = 512'hC1;
    tick();
    in_req_key_wr = 2'b00;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_req_key_wr = 2'b01;
        in_req_key[0 +: KEY_W] = 512'hDEAD;
      end
      tick();
      in_req_key_wr = 2'b00;
      checks++; if (out_lkp_key_wr !== 1'b0) begin errors++; $display("FAIL bp_no_issue: got %b required 0 at cycle %0d", out_lkp_key_wr, c); end
    end
    checks++; if (out_drop_count !== 32'd1) begin errors++; $display("FAIL bp_drop: got %0d required 1", out_drop_count); end
    checks++; if (out_req_key_alf !== 2'b11) begin errors++; $display("FAIL bp_alf: got %b required 11", out_req_key_alf); end
    exp_key_q.push_back(512'hC0);
    exp_key_q.push_back(512'hC1);
    in_lkp_key_alf = 1'b0;
    repeat (4) tick();
    checks++; if (out_grant_count[31:0] !== 32'd1 || out_grant_count[63:32] !== 32'd1) begin errors++; $display("FAIL bp_grants: got %0d/%0d required 1/1", out_grant_count[31:0], out_grant_count[63:32]); end
    in_lkp_index_wr = 1'b1;
    in_lkp_index = 16'h0300;
    exp_idx_q.push_back({2'b01, 16'h0300});
    tick();
    in_lkp_index = 16'h0301;
    exp_idx_q.push_back({2'b10, 16'h0301});
    tick();
    in_lkp_index_wr = 1'b0;
    wait_drain(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got %0d/%0d pending required 0/0", exp_key_q.size(), exp_idx_q.size()); end
  endtask

  task automatic test_tag_full();
    bit ok;
    do_reset();
    for (int j = 0; j < 33; j++) begin
      in_req_key_wr = 2'b01;
      in_req_key[0 +: KEY_W] = KEY_W'(32'h1000 + j);
      if (j < 32) exp_key_q.push_back(KEY_W'(32'h1000 + j));
      tick();
    end
    in_req_key_wr = 2'b00;
    repeat (8) tick();
    checks++; if (out_tag_usedw !== 6'd32) begin errors++; $display("FAIL full_usedw: got %0d required 32", out_tag_usedw); end
    checks++; if (out_req_key_alf !== 2'b11) begin errors++; $display("FAIL full_alf: got %b required 11", out_req_key_alf); end
    checks++; if (out_grant_count[31:0] !== 32'd32) begin errors++; $display("FAIL full_stall: got %0d required 32", out_grant_count[31:0]); end
    exp_key_q.push_back(KEY_W'(32'h1000 + 32));
    exp_idx_q.push_back({2'b01, 16'h0400});
    in_lkp_index_wr = 1'b1;
    in_lkp_index = 16'h0400;
    tick();
    in_lkp_index_wr = 1'b0;
    repeat (6) tick();
    checks++; if (out_grant_count[31:0] !== 32'd33) begin errors++; $display("FAIL full_one_more: got %0d required 33", out_grant_count[31:0]); end
    checks++; if (out_tag_usedw !== 6'd32) begin errors++; $display("FAIL full_usedw_after: got %0d required 32", out_tag_usedw); end
    wait_drain(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_drain: got %0d/%0d pending required 0/0", exp_key_q.size(), exp_idx_q.size()); end
  endtask

  task automatic test_orphan_reset();
    bit ok;
    do_reset();
    in_lkp_index_wr = 1'b1;
    in_lkp_index = 16'hBEEF;
    tick();
    in_lkp_index_wr = 1'b0;
    checks++; if (out_orphan_count !== 32'd1) begin errors++; $display("FAIL orphan_count: got %0d required 1", out_orphan_count); end
    checks++; if (out_req_index_wr !== 2'b00) begin errors++; $display("FAIL orphan_no_deliver: got %b required 00", out_req_index_wr); end
    for (int j = 0; j < 5; j++) begin
      in_req_key_wr = 2'b10;
      in_req_key[KEY_W +: KEY_W] = KEY_W'(32'h2000 + j);
      exp_key_q.push_back(KEY_W'(32'h2000 + j));
      tick();
    end
    in_req_key_wr = 2'b00;
    repeat (3) tick();
    checks++; if (out_tag_usedw !== 6'd5) begin errors++; $display("FAIL rst5_usedw_before: got %0d required 5", out_tag_usedw); end
    checks++; if (out_grant_count[63:32] !== 32'd5) begin errors++; $display("FAIL rst5_grant_before: got %0d required 5", out_grant_count[63:32]); end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checks++; if (out_tag_usedw !== 6'd0) begin errors++; $display("FAIL rst5_usedw: got %0d required 0", out_tag_usedw); end
    checks++; if (out_grant_count !== 64'd0 || out_drop_count !== 32'd0 || out_orphan_count !== 32'd0) begin errors++; $display("FAIL rst5_counters: got g=%h d=%0d o=%0d required 0", out_grant_count, out_drop_count, out_orphan_count); end
    checks++; if (out_lkp_key !== '0) begin errors++; $display("FAIL rst5_key: got %h required 0", out_lkp_key[63:0]); end
    in_lkp_index_wr = 1'b1;
    in_lkp_index = 16'h0555;
    tick();
    in_lkp_index_wr = 1'b0;
    checks++; if (out_orphan_count !== 32'd1 || out_req_index_wr !== 2'b00) begin errors++; $display("FAIL rst5_post_orphan: got o=%0d wr=%b required 1/00", out_orphan_count, out_req_index_wr); end
    wait_drain(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL orphan_drain: got %0d/%0d pending required 0/0", exp_key_q.size(), exp_idx_q.size()); end
  endtask

  initial begin
    srst            = 1'b1;
    in_req_key_wr   = '0;
    in_req_key      = '0;
    in_lkp_key_alf  = 1'b0;
    in_lkp_index_wr = 1'b0;
    in_lkp_index    = '0;
    cfg_arb_en      = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_tag_full();
    test_orphan_reset();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
